// File: rtl/dp_ram_burst_reader_if.sv
// Signal bundle between the burst reader, its requester, the RAM read port and the consumer.
// "master" is the reader's own view; "slave" is the view of everything around it.
interface dp_ram_burst_reader_if #(
   parameter int C_DAT_W = 8,
   parameter int C_ADR_W = 10
);
   logic               REQ_i;
   logic [C_ADR_W-1:0] SAs_i;
   logic [C_ADR_W:0]   LEN_i;
   logic               ACK_o;
   logic               BUSY_o;
   logic [C_ADR_W-1:0] RAs_o;
   logic [C_DAT_W-1:0] RDs_i;
   logic [C_DAT_W-1:0] DAT_o;
   logic               DV_o;
   logic               DRDY_i;
   logic               LAST_o;
   logic               DONE_o;

   modport master (
      input  REQ_i, SAs_i, LEN_i, RDs_i, DRDY_i,
      output ACK_o, BUSY_o, RAs_o, DAT_o, DV_o, LAST_o, DONE_o
   );

   modport slave (
      output REQ_i, SAs_i, LEN_i, RDs_i, DRDY_i,
      input  ACK_o, BUSY_o, RAs_o, DAT_o, DV_o, LAST_o, DONE_o
   );
endinterface

// File: rtl/dp_ram_burst_reader.sv
// Burst read master for the dual-port RAM: issues sequential addresses, tracks the fixed
// read latency and streams returned words through a small first-word-fall-through FIFO.
module dp_ram_burst_reader #(
   parameter int C_DAT_W      = 8,
   parameter int C_ADR_W      = 10,
   parameter int C_RD_LAT     = 2,
   parameter int C_FIFO_DEPTH = 4
) (
   input  logic                  CK_i,
   input  logic                  RST_i,
   dp_ram_burst_reader_if.master bus
);
   localparam int PTR_W = $clog2(C_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = PTR_W + 2;
   localparam int LEN_W = C_ADR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t             state_reg;
   logic [C_ADR_W-1:0] ras_reg;
   logic [LEN_W-1:0]   remain_reg;
   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   xfer_reg;
   logic               ack_reg;
   logic               busy_reg;
   logic               done_reg;

   logic [C_RD_LAT-1:0] flight_reg;
   logic [C_RD_LAT-1:0] flight_next;
   logic [CNT_W-1:0]    flight_cnt;

   logic [C_DAT_W-1:0] fifo_mem [C_FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;

   logic [OCC_W-1:0] occ;
   logic             accept;
   logic             can_issue;
   logic             issue;
   logic             capture;
   logic             dv;
   logic             pop;
   logic             last;
   logic             final_xfer;

   assign accept     = (state_reg == IDLE) && bus.REQ_i;
   // Credit counts everything already committed; a pop in the same cycle is not credited.
   assign occ        = OCC_W'(count_reg) + OCC_W'(flight_cnt);
   assign can_issue  = (state_reg == ISSUE) && (occ < OCC_W'(C_FIFO_DEPTH));
   assign issue      = (accept && (bus.LEN_i != '0)) || can_issue;
   assign capture    = flight_reg[C_RD_LAT-1];
   assign dv         = (count_reg != '0);
   assign pop        = dv && bus.DRDY_i;
   assign last       = dv && (xfer_reg == len_reg - LEN_W'(1));
   assign final_xfer = pop && last;

   always_comb begin
      flight_cnt = '0;
      for (int i = 0; i < C_RD_LAT; i++)
         flight_cnt = flight_cnt + CNT_W'(flight_reg[i]);
   end

   // Valid tokens ride alongside the RAM pipeline so data is captured exactly C_RD_LAT edges later.
   assign flight_next[0] = issue;
   genvar gi;
   generate
      for (gi = 1; gi < C_RD_LAT; gi++) begin : g_flight
         assign flight_next[gi] = flight_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         flight_reg <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         flight_reg <= flight_next;
         if (capture)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CNT_W'(capture) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CK_i) begin
      if (capture)
         fifo_mem[wr_ptr_reg] <= bus.RDs_i;
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         state_reg  <= IDLE;
         ras_reg    <= '0;
         remain_reg <= '0;
         len_reg    <= '0;
         xfer_reg   <= '0;
         ack_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         ack_reg  <= 1'b0;
         done_reg <= 1'b0;
         if (pop)
            xfer_reg <= xfer_reg + 1'b1;
         case (state_reg)
            IDLE: begin
               if (bus.REQ_i) begin
                  ack_reg  <= 1'b1;
                  busy_reg <= 1'b1;
                  len_reg  <= bus.LEN_i;
                  xfer_reg <= '0;
                  if (bus.LEN_i != '0) begin
                     ras_reg    <= bus.SAs_i;
                     remain_reg <= bus.LEN_i - LEN_W'(1);
                     state_reg  <= (bus.LEN_i == LEN_W'(1)) ? DRAIN : ISSUE;
                  end else begin
                     remain_reg <= '0;
                     state_reg  <= DRAIN;
                  end
               end
            end
            ISSUE: begin
               if (can_issue) begin
                  ras_reg    <= ras_reg + 1'b1;
                  remain_reg <= remain_reg - LEN_W'(1);
                  if (remain_reg == LEN_W'(1))
                     state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if ((len_reg == '0) || final_xfer) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assert property (@(posedge CK_i) disable iff (RST_i)
      !(capture && !pop && (count_reg == CNT_W'(C_FIFO_DEPTH))));

   assign bus.ACK_o  = ack_reg;
   assign bus.BUSY_o = busy_reg;
   assign bus.RAs_o  = ras_reg;
   assign bus.DAT_o  = dv ? fifo_mem[rd_ptr_reg] : '0;
   assign bus.DV_o   = dv;
   assign bus.LAST_o = last;
   assign bus.DONE_o = done_reg;
endmodule

// File: tb/tb_dp_ram_burst_reader.sv
// Directed bench for dp_ram_burst_reader: a 2-edge-latency RAM model, cycle-stepped
// stimulus and a queue of received words compared against the RAM's known contents.
module tb_dp_ram_burst_reader;
   localparam int DW = 8;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dp_ram_burst_reader_if #(.C_DAT_W(DW), .C_ADR_W(AW)) bus ();

   dp_ram_burst_reader #(
      .C_DAT_W(DW), .C_ADR_W(AW), .C_RD_LAT(2), .C_FIFO_DEPTH(4)
   ) dut (
      .CK_i(clk),
      .RST_i(rst),
      .bus(bus)
   );

   function automatic logic [DW-1:0] ram_val(input int a);
      return DW'((a * 37 + 11) ^ (a >> 3));
   endfunction

   // Address sampled at edge e+1, data presented for capture at edge e+2.
   logic [DW-1:0] ram [1<<AW];
   logic [DW-1:0] rd_q = '0;
   always @(posedge clk) rd_q <= ram[bus.RAs_o];
   assign bus.RDs_i = rd_q;

   int n_pass = 0;
   int n_total = 0;
   logic [DW-1:0] rx_q [$];
   int last_cnt, last_pos, done_cnt, ack_cnt, issued, max_out;
   int mode, bp_left;
   bit bp_done;
   logic [AW-1:0] prev_ras = '0;
   logic [AW:0] len_cur = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      if (!rst && bus.DV_o && bus.DRDY_i) begin
         rx_q.push_back(bus.DAT_o);
         if (bus.LAST_o) begin
            last_cnt++;
            last_pos = rx_q.size();
         end
      end
      @(posedge clk);
      #1;
      if (bus.DONE_o) done_cnt++;
      if (bus.ACK_o) ack_cnt++;
      if (bus.ACK_o && len_cur != 0) issued = 1;
      else if (bus.BUSY_o && bus.RAs_o != prev_ras) issued++;
      prev_ras = bus.RAs_o;
      if (issued - rx_q.size() > max_out) max_out = issued - rx_q.size();
   endtask

   task automatic drive_drdy();
      case (mode)
         0: bus.DRDY_i = 1'b1;
         1: begin
            if (bp_left > 0) begin
               bus.DRDY_i = 1'b0;
               bp_left--;
            end else if (!bp_done && rx_q.size() == 2) begin
               bp_done = 1'b1;
               bp_left = 9;
               bus.DRDY_i = 1'b0;
            end else begin
               bus.DRDY_i = 1'b1;
            end
         end
         default: bus.DRDY_i = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic start(input logic [AW-1:0] sa, input logic [AW:0] len);
      rx_q.delete();
      last_cnt = 0; last_pos = 0; done_cnt = 0; ack_cnt = 0;
      issued = 0; max_out = 0; bp_done = 1'b0; bp_left = 0;
      len_cur = len;
      bus.REQ_i = 1'b1;
      bus.SAs_i = sa;
      bus.LEN_i = len;
      drive_drdy();
      tick();
      bus.REQ_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         drive_drdy();
         tick();
         n++;
      end
   endtask

   task automatic check_words(input string tag, input logic [AW-1:0] sa, input int len);
      chk({tag, "_count"}, rx_q.size(), len);
      for (int i = 0; i < len && i < rx_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), rx_q[i], ram_val((int'(sa) + i) % (1 << AW)));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"},  bus.ACK_o,  0);
      chk({tag, "_busy"}, bus.BUSY_o, 0);
      chk({tag, "_ras"},  bus.RAs_o,  0);
      chk({tag, "_dv"},   bus.DV_o,   0);
      chk({tag, "_last"}, bus.LAST_o, 0);
      chk({tag, "_done"}, bus.DONE_o, 0);
      chk({tag, "_dat"},  bus.DAT_o,  0);
   endtask

   task automatic report(input string name, input logic [AW-1:0] sa, input int len);
      $display("burst %s sa=0x%03h len=%0d words=%0d last=%0d done=%0d max_outstanding=%0d",
               name, sa, len, rx_q.size(), last_cnt, done_cnt, max_out);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] exp_ras [1:7];
      logic [7:1] exp_ack, exp_busy, exp_dv, exp_last, exp_done;
      logic [AW-1:0] wrap_ras [0:3];
      int err;
      int n;

      for (int i = 0; i < (1 << AW); i++) ram[i] = ram_val(i);
      bus.REQ_i = 1'b0; bus.SAs_i = '0; bus.LEN_i = '0; bus.DRDY_i = 1'b1;
      mode = 0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Test 1: basic burst, cycle-exact
      exp_ras  = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h013, 10'h013, 10'h013};
      exp_ack  = 7'b0000001;
      exp_busy = 7'b0111111;
      exp_dv   = 7'b0111100;
      exp_last = 7'b0100000;
      exp_done = 7'b1000000;
      mode = 0;
      start(10'h010, 11'd4);
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("t1_ack_c%0d", k),  bus.ACK_o,  exp_ack[k]);
         chk($sformatf("t1_busy_c%0d", k), bus.BUSY_o, exp_busy[k]);
         chk($sformatf("t1_ras_c%0d", k),  bus.RAs_o,  exp_ras[k]);
         chk($sformatf("t1_dv_c%0d", k),   bus.DV_o,   exp_dv[k]);
         chk($sformatf("t1_last_c%0d", k), bus.LAST_o, exp_last[k]);
         chk($sformatf("t1_done_c%0d", k), bus.DONE_o, exp_done[k]);
         if (exp_dv[k])
            chk($sformatf("t1_dat_c%0d", k), bus.DAT_o, ram_val(16 + k - 3));
         if (k < 7) tick();
      end
      report("basic", 10'h010, 4);

      // Test 2: address wrap
      wrap_ras = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      start(10'h3FE, 11'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_ras_c%0d", k + 1), bus.RAs_o, wrap_ras[k]);
         drive_drdy();
         tick();
      end
      wait_done(50);
      chk("t2_done", done_cnt, 1);
      check_words("t2", 10'h3FE, 4);
      chk("t2_last_pos", last_pos, 4);
      report("wrap", 10'h3FE, 4);

      // Test 3: backpressure
      mode = 1;
      start(10'h120, 11'd16);
      wait_done(200);
      chk("t3_done", done_cnt, 1);
      check_words("t3", 10'h120, 16);
      chk("t3_last_cnt", last_cnt, 1);
      chk("t3_last_pos", last_pos, 16);
      chk("t3_issued", issued, 16);
      chk("t3_max_outstanding", max_out, 4);
      report("backpressure", 10'h120, 16);

      // Test 4a: zero length
      mode = 0;
      start(10'h100, 11'd0);
      chk("t4_ack",   bus.ACK_o,  1);
      chk("t4_busy",  bus.BUSY_o, 1);
      chk("t4_dv_c1", bus.DV_o,   0);
      chk("t4_done_c1", bus.DONE_o, 0);
      tick();
      chk("t4_done_c2", bus.DONE_o, 1);
      chk("t4_busy_c2", bus.BUSY_o, 0);
      chk("t4_dv_c2",   bus.DV_o,   0);
      tick();
      chk("t4_words", rx_q.size(), 0);
      report("zero", 10'h100, 0);

      // Test 4b: request while busy is ignored
      start(10'h200, 11'd8);
      tick();
      bus.REQ_i = 1'b1; bus.SAs_i = 10'h300; bus.LEN_i = 11'd5;
      for (int k = 0; k < 3; k++) tick();
      bus.REQ_i = 1'b0;
      wait_done(100);
      chk("t4b_ack_cnt", ack_cnt, 1);
      chk("t4b_done", done_cnt, 1);
      check_words("t4b", 10'h200, 8);
      chk("t4b_last_pos", last_pos, 8);
      report("busy_req", 10'h200, 8);

      // Test 5: reset mid-burst
      start(10'h040, 11'd16);
      n = 0;
      while (rx_q.size() < 5 && n < 100) begin
         drive_drdy();
         tick();
         n++;
      end
      chk("t5_words_before_reset", rx_q.size(), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("t5_after_reset");
      for (int k = 0; k < 3; k++) tick();
      chk("t5_no_done", done_cnt, 0);
      chk("t5_idle_busy", bus.BUSY_o, 0);
      start(10'h080, 11'd2);
      wait_done(50);
      chk("t5_done", done_cnt, 1);
      check_words("t5", 10'h080, 2);
      chk("t5_last_cnt", last_cnt, 1);
      chk("t5_last_pos", last_pos, 2);
      report("after_reset", 10'h080, 2);

      // Test 6: full address space with random consumer stalls
      mode = 2;
      start(10'h000, 11'd1024);
      wait_done(8000);
      mode = 0;
      for (int k = 0; k < 4; k++) begin
         drive_drdy();
         tick();
      end
      err = 0;
      for (int i = 0; i < rx_q.size(); i++)
         if (rx_q[i] !== ram_val(i)) err++;
      chk("t6_count", rx_q.size(), 1024);
      chk("t6_data_errors", err, 0);
      chk("t6_last_cnt", last_cnt, 1);
      chk("t6_last_pos", last_pos, 1024);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_max_outstanding_le4", (max_out <= 4), 1);
      report("full", 10'h000, 1024);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
